// File: rtl/vdp_pkg.sv
// Shared types and sizing helpers for the video output pipeline.
package vdp_pkg;

    typedef enum logic [1:0] {
        FADE_NOP  = 2'd0,
        FADE_OUT  = 2'd1,
        FADE_IN   = 2'd2,
        FADE_SNAP = 2'd3
    } fade_cmd_e;

    typedef enum logic [1:0] {
        StIdle,
        StFadeOut,
        StFadeIn
    } fade_state_e;

    // Internal signed width: room for unsigned luma plus sign, and two guard bits.
    function automatic int unsigned calc_iw(int unsigned yw, int unsigned cw);
        return (((yw + 1) > cw) ? (yw + 1) : cw) + 2;
    endfunction

endpackage

// File: rtl/ycocg_to_rgb.sv
// YCoCg-R to RGB conversion (S2..S4), then clamp, bit-replicating scale and de blanking (S5).
module ycocg_to_rgb
    import vdp_pkg::*;
#(
    parameter int unsigned YW   = 7,
    parameter int unsigned CW   = 8,
    parameter int unsigned OUTW = 8
) (
    input  logic            clk_pix,
    input  logic            rst_pix_n,
    input  logic [YW-1:0]   y_f,
    input  logic [CW-1:0]   co,
    input  logic [CW-1:0]   cg,
    input  logic            de_s4,
    output logic [OUTW-1:0] r,
    output logic [OUTW-1:0] g,
    output logic [OUTW-1:0] b
);

    localparam int unsigned IW = calc_iw(YW, CW);
    localparam logic signed [IW-1:0] YMAX_S = IW'((1 << YW) - 1);

    function automatic logic [YW-1:0] clamp_y(logic signed [IW-1:0] v);
        if (v[IW-1]) return '0;
        else if (v > YMAX_S) return {YW{1'b1}};
        else return v[YW-1:0];
    endfunction

    // Repeat the MSBs into the low bits so full scale maps to all ones.
    function automatic logic [OUTW-1:0] scale_y(logic [YW-1:0] c);
        logic [OUTW-1:0] s;
        for (int i = 0; i < OUTW; i++) begin
            s[OUTW-1-i] = c[YW-1-(i % YW)];
        end
        return s;
    endfunction

    logic signed [IW-1:0] y_ext, co_ext, cg_ext;
    logic signed [IW-1:0] tmp2_d, co2_d, cg2_d, tmp2_q, co2_q, cg2_q;
    logic signed [IW-1:0] g3_d, b3_d, co3_d, g3_q, b3_q, co3_q;
    logic signed [IW-1:0] r4_d, g4_d, b4_d, r4_q, g4_q, b4_q;
    logic [OUTW-1:0]      r_d, g_d, b_d, r_q, g_q, b_q;

    assign y_ext  = $signed({{(IW-YW){1'b0}}, y_f});
    assign co_ext = $signed({{(IW-CW){co[CW-1]}}, co});
    assign cg_ext = $signed({{(IW-CW){cg[CW-1]}}, cg});

    always_comb begin
        tmp2_d = y_ext - (cg_ext >>> 1);
        co2_d  = co_ext;
        cg2_d  = cg_ext;
        g3_d   = cg2_q + tmp2_q;
        b3_d   = tmp2_q - (co2_q >>> 1);
        co3_d  = co2_q;
        r4_d   = b3_q + co3_q;
        g4_d   = g3_q;
        b4_d   = b3_q;
        r_d    = '0;
        g_d    = '0;
        b_d    = '0;
        if (de_s4) begin
            r_d = scale_y(clamp_y(r4_q));
            g_d = scale_y(clamp_y(g4_q));
            b_d = scale_y(clamp_y(b4_q));
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            tmp2_q <= '0;
            co2_q  <= '0;
            cg2_q  <= '0;
            g3_q   <= '0;
            b3_q   <= '0;
            co3_q  <= '0;
            r4_q   <= '0;
            g4_q   <= '0;
            b4_q   <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            tmp2_q <= tmp2_d;
            co2_q  <= co2_d;
            cg2_q  <= cg2_d;
            g3_q   <= g3_d;
            b3_q   <= b3_d;
            co3_q  <= co3_d;
            r4_q   <= r4_d;
            g4_q   <= g4_d;
            b4_q   <= b4_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
        end
    end

    assign r = r_q;
    assign g = g_q;
    assign b = b_q;

endmodule

// File: rtl/ycocg_fade_pipe.sv
// Pixel output stage: frame-synchronous luma fade (S1), YCoCg to RGB, 5-stage timing delay line.
module ycocg_fade_pipe
    import vdp_pkg::*;
#(
    parameter int unsigned CORDW            = 11,
    parameter int unsigned YW               = 7,
    parameter int unsigned CW               = 8,
    parameter int unsigned OUTW             = 8,
    parameter int unsigned FADE_STEP_FRAMES = 2
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic [CORDW-1:0] in_sx,
    input  logic [CORDW-1:0] in_sy,
    input  logic             in_de,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic             in_frame,
    input  logic [YW-1:0]    in_y,
    input  logic [CW-1:0]    in_co,
    input  logic [CW-1:0]    in_cg,
    input  logic [1:0]       fade_cmd,
    input  logic             fade_cmd_valid,
    output logic             fade_busy,
    output logic [YW-1:0]    fade_level,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic [OUTW-1:0]  r,
    output logic [OUTW-1:0]  g,
    output logic [OUTW-1:0]  b
);

    localparam int unsigned     TW       = 2 * CORDW + 3;
    localparam int unsigned     DIVW     = $clog2(FADE_STEP_FRAMES + 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(FADE_STEP_FRAMES);
    localparam logic [YW-1:0]   YMAX     = {YW{1'b1}};

    fade_cmd_e       cmd;
    fade_state_e     state_d, state_q;
    logic [YW-1:0]   level_d, level_q;
    logic [DIVW-1:0] div_d, div_q, div_inc;
    logic            busy_d, busy_q;

    assign cmd = fade_cmd_e'(fade_cmd);

    // An accepted command takes priority over a coincident in_frame pulse.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        div_d   = div_q;
        div_inc = div_q + 1'b1;
        if (fade_cmd_valid && cmd == FADE_SNAP) begin
            state_d = StIdle;
            level_d = YMAX;
            div_d   = '0;
        end else if (fade_cmd_valid && state_q == StIdle && cmd == FADE_OUT
                     && level_q != '0) begin
            state_d = StFadeOut;
            div_d   = '0;
        end else if (fade_cmd_valid && state_q == StIdle && cmd == FADE_IN
                     && level_q != YMAX) begin
            state_d = StFadeIn;
            div_d   = '0;
        end else if (in_frame && state_q != StIdle) begin
            if (div_inc == DIV_LAST) begin
                div_d = '0;
                if (state_q == StFadeOut) begin
                    level_d = level_q - 1'b1;
                    if (level_q == YW'(1)) state_d = StIdle;
                end else begin
                    level_d = level_q + 1'b1;
                    if (level_q == YMAX - 1'b1) state_d = StIdle;
                end
            end else begin
                div_d = div_inc;
            end
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q <= StIdle;
            level_q <= YMAX;
            div_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            div_q   <= div_d;
            busy_q  <= busy_d;
        end
    end

    assign fade_busy  = busy_q;
    assign fade_level = level_q;

    // S1: darken luma by the current fade deficit, saturating at zero.
    logic [YW-1:0] deficit, yf_d, yf_q;
    logic [CW-1:0] co1_d, cg1_d, co1_q, cg1_q;

    always_comb begin
        deficit = YMAX - level_q;
        yf_d    = (in_y >= deficit) ? (in_y - deficit) : '0;
        co1_d   = in_co;
        cg1_d   = in_cg;
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            yf_q  <= '0;
            co1_q <= '0;
            cg1_q <= '0;
        end else begin
            yf_q  <= yf_d;
            co1_q <= co1_d;
            cg1_q <= cg1_d;
        end
    end

    logic [TW-1:0] tim_d [5];
    logic [TW-1:0] tim_q [5];

    always_comb begin
        tim_d[0] = {in_sx, in_sy, in_de, in_hsync, in_vsync};
        for (int i = 1; i < 5; i++) begin
            tim_d[i] = tim_q[i-1];
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            for (int i = 0; i < 5; i++) tim_q[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) tim_q[i] <= tim_d[i];
        end
    end

    assign {sx, sy, de, hsync, vsync} = tim_q[4];

    ycocg_to_rgb #(
        .YW   (YW),
        .CW   (CW),
        .OUTW (OUTW)
    ) u_rgb (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .y_f       (yf_q),
        .co        (co1_q),
        .cg        (cg1_q),
        .de_s4     (tim_q[3][2]),
        .r         (r),
        .g         (g),
        .b         (b)
    );

endmodule

// File: tb/tb_ycocg_fade_pipe.sv
// Self-checking bench for ycocg_fade_pipe: random pixels against an arithmetic model plus fade scenarios.
module tb_ycocg_fade_pipe;

    localparam int CORDW = 11;
    localparam int YW    = 7;
    localparam int CW    = 8;
    localparam int OUTW  = 8;
    localparam int STEP  = 2;
    localparam int YMAX  = (1 << YW) - 1;

    logic             clk = 1'b0;
    logic             rst_pix_n = 1'b0;
    logic [CORDW-1:0] in_sx = '0, in_sy = '0;
    logic             in_de = 1'b0, in_hsync = 1'b0, in_vsync = 1'b0, in_frame = 1'b0;
    logic [YW-1:0]    in_y = '0;
    logic [CW-1:0]    in_co = '0, in_cg = '0;
    logic [1:0]       fade_cmd = '0;
    logic             fade_cmd_valid = 1'b0;
    logic             fade_busy;
    logic [YW-1:0]    fade_level;
    logic [CORDW-1:0] sx, sy;
    logic             de, hsync, vsync;
    logic [OUTW-1:0]  r, g, b;

    ycocg_fade_pipe #(
        .CORDW            (CORDW),
        .YW               (YW),
        .CW               (CW),
        .OUTW             (OUTW),
        .FADE_STEP_FRAMES (STEP)
    ) dut (
        .clk_pix        (clk),
        .rst_pix_n      (rst_pix_n),
        .in_sx          (in_sx),
        .in_sy          (in_sy),
        .in_de          (in_de),
        .in_hsync       (in_hsync),
        .in_vsync       (in_vsync),
        .in_frame       (in_frame),
        .in_y           (in_y),
        .in_co          (in_co),
        .in_cg          (in_cg),
        .fade_cmd       (fade_cmd),
        .fade_cmd_valid (fade_cmd_valid),
        .fade_busy      (fade_busy),
        .fade_level     (fade_level),
        .sx             (sx),
        .sy             (sy),
        .de             (de),
        .hsync          (hsync),
        .vsync          (vsync),
        .r              (r),
        .g              (g),
        .b              (b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CORDW-1:0] sx;
        logic [CORDW-1:0] sy;
        logic             de;
        logic             hs;
        logic             vs;
        logic [OUTW-1:0]  r;
        logic [OUTW-1:0]  g;
        logic [OUTW-1:0]  b;
    } pix_t;

    int   total = 0;
    int   bad = 0;
    int   m_level, m_mode, m_div;   // mode: 0 idle, 1 fading out, 2 fading in
    pix_t q[$];
    pix_t cur;

    function automatic int clampv(int v);
        if (v < 0) return 0;
        if (v > YMAX) return YMAX;
        return v;
    endfunction

    function automatic logic [OUTW-1:0] scalev(int v);
        return OUTW'((v << (OUTW - YW)) + (v >> (2 * YW - OUTW)));
    endfunction

    function automatic int floor_half(int v);
        return (v >= 0) ? v / 2 : -((-v + 1) / 2);
    endfunction

    function automatic pix_t ref_pix(int x, int y, int d, int hs, int vs,
                                     int yy, int co, int cg, int lvl);
        pix_t p;
        int yf, tmp, gg, bb, rr;
        yf = yy - (YMAX - lvl);
        if (yf < 0) yf = 0;
        tmp = yf - floor_half(cg);
        gg  = cg + tmp;
        bb  = tmp - floor_half(co);
        rr  = bb + co;
        p.sx = CORDW'(x);
        p.sy = CORDW'(y);
        p.de = d[0];
        p.hs = hs[0];
        p.vs = vs[0];
        p.r  = d[0] ? scalev(clampv(rr)) : '0;
        p.g  = d[0] ? scalev(clampv(gg)) : '0;
        p.b  = d[0] ? scalev(clampv(bb)) : '0;
        return p;
    endfunction

    task automatic reset_model();
        m_level = YMAX;
        m_mode  = 0;
        m_div   = 0;
        q.delete();
        repeat (4) q.push_back('0);
    endtask

    task automatic tick(int x, int y, int d, int hs, int vs, int yy, int co, int cg,
                        int cmd, int cv, int fr);
        in_sx = CORDW'(x);
        in_sy = CORDW'(y);
        in_de = d[0];
        in_hsync = hs[0];
        in_vsync = vs[0];
        in_y = YW'(yy);
        in_co = CW'(co);
        in_cg = CW'(cg);
        fade_cmd = 2'(cmd);
        fade_cmd_valid = cv[0];
        in_frame = fr[0];
        q.push_back(ref_pix(x, y, d, hs, vs, yy, co, cg, m_level));
        @(posedge clk);
        if (cv != 0 && cmd == 3) begin
            m_level = YMAX;
            m_mode  = 0;
            m_div   = 0;
        end else if (cv != 0 && m_mode == 0 && cmd == 1 && m_level > 0) begin
            m_mode = 1;
            m_div  = 0;
        end else if (cv != 0 && m_mode == 0 && cmd == 2 && m_level < YMAX) begin
            m_mode = 2;
            m_div  = 0;
        end else if (fr != 0 && m_mode != 0) begin
            m_div++;
            if (m_div == STEP) begin
                m_div = 0;
                m_level += (m_mode == 1) ? -1 : 1;
                if (m_level == 0 || m_level == YMAX) m_mode = 0;
            end
        end
        #1;
        cur = q.pop_front();
        fade_cmd_valid = 1'b0;
        in_frame = 1'b0;
    endtask

    task automatic tick_grey(int yy, int cmd, int cv, int fr);
        tick($urandom_range(0, 2047), $urandom_range(0, 2047), 1, 0, 0, yy, 0, 0, cmd, cv, fr);
    endtask

    task automatic test_reset();
        total++;
        if ({sx, sy, de, hsync, vsync, r, g, b} !== '0 || fade_level !== 7'd127
            || fade_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_initial got out=%h lvl=%0d busy=%b want 0/127/0",
                     {sx, sy, de, hsync, vsync, r, g, b}, fade_level, fade_busy);
        end
        #2 rst_pix_n = 1'b1;
        reset_model();
        tick_grey(100, 1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            tick($urandom_range(1, 2047), $urandom_range(1, 2047), 1, 1, 1,
                 $urandom_range(0, 127), 0, 0, 0, 0, i % 2);
        end
        total++;
        if (fade_level !== 7'(m_level) || fade_busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_fade got lvl=%0d busy=%b want %0d/1",
                     fade_level, fade_busy, m_level);
        end
        #2 rst_pix_n = 1'b0;
        #1;
        total++;
        if ({sx, sy, de, hsync, vsync, r, g, b} !== '0 || fade_level !== 7'd127
            || fade_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_midstream got out=%h lvl=%0d busy=%b want 0/127/0",
                     {sx, sy, de, hsync, vsync, r, g, b}, fade_level, fade_busy);
        end
        #1 rst_pix_n = 1'b1;
        reset_model();
    endtask

    task automatic test_grey_latency();
        int x, y;
        x = $urandom_range(0, 2047);
        y = $urandom_range(0, 2047);
        tick(x, y, 1, 1, 1, 64, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick($urandom_range(0, 2047), $urandom_range(0, 2047), 0,
                 $urandom_range(0, 1), $urandom_range(0, 1), 64, 0, 0, 0, 0, 0);
            if (i == 3) begin
                total++;
                if (r !== 8'd129 || g !== 8'd129 || b !== 8'd129 || sx !== CORDW'(x)
                    || sy !== CORDW'(y) || de !== 1'b1 || hsync !== 1'b1 || vsync !== 1'b1) begin
                    bad++;
                    $display("FAIL grey_latency got rgb=%0d,%0d,%0d sx=%0d sy=%0d want 129 %0d %0d",
                             r, g, b, sx, sy, x, y);
                end
            end
            if (i == 4) begin
                total++;
                if ({r, g, b} !== 24'd0) begin
                    bad++;
                    $display("FAIL de_low_blank got rgb=%h want 0", {r, g, b});
                end
            end
            total++;
            if ({sx, sy, de, hsync, vsync, r, g, b} !== cur) begin
                bad++;
                $display("FAIL grey_model[%0d] got %h want %h", i,
                         {sx, sy, de, hsync, vsync, r, g, b}, cur);
            end
        end
    endtask

    task automatic test_clamp();
        int          ty [2] = '{127, 0};
        int          tco[2] = '{127, -128};
        int          tcg[2] = '{0, 127};
        logic [23:0] want [2] = '{{8'd255, 8'd255, 8'd129}, {8'd0, 8'd129, 8'd2}};
        for (int i = 0; i < 6; i++) begin
            if (i < 2) tick(i, i, 1, 0, 0, ty[i], tco[i], tcg[i], 0, 0, 0);
            else       tick(i, i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (i >= 4) begin
                total++;
                if ({r, g, b} !== want[i-4]) begin
                    bad++;
                    $display("FAIL clamp[%0d] got rgb=%h want %h", i - 4, {r, g, b}, want[i-4]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            tick($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 127),
                 $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 0, 0, 0);
            total++;
            if ({sx, sy, de, hsync, vsync, r, g, b} !== cur) begin
                bad++;
                $display("FAIL rand_pix[%0d] got %h want %h", i,
                         {sx, sy, de, hsync, vsync, r, g, b}, cur);
            end
        end
    endtask

    task automatic test_fade_out();
        tick_grey(127, 1, 1, 0);
        total++;
        if (fade_busy !== 1'b1 || fade_level !== 7'd127) begin
            bad++;
            $display("FAIL fade_out_start got busy=%b lvl=%0d want 1/127", fade_busy, fade_level);
        end
        for (int p = 1; p <= 254; p++) begin
            tick_grey(127, 0, 0, 1);
            tick_grey(127, 0, 0, 0);
            total++;
            if (fade_level !== 7'(m_level) || fade_busy !== (m_mode != 0)
                || {r, g, b} !== {cur.r, cur.g, cur.b}) begin
                bad++;
                $display("FAIL fade_out_step[%0d] got lvl=%0d busy=%b rgb=%h want %0d %0d %h", p,
                         fade_level, fade_busy, {r, g, b}, m_level, m_mode != 0,
                         {cur.r, cur.g, cur.b});
            end
            if (p == 2) begin
                repeat (5) tick_grey(127, 0, 0, 0);
                total++;
                if (fade_level !== 7'd126 || {r, g, b} !== {3{8'd253}}) begin
                    bad++;
                    $display("FAIL fade_out_126 got lvl=%0d rgb=%h want 126 fdfdfd",
                             fade_level, {r, g, b});
                end
            end
        end
        repeat (5) tick_grey(127, 0, 0, 0);
        total++;
        if (fade_level !== 7'd0 || fade_busy !== 1'b0 || {r, g, b} !== 24'd0) begin
            bad++;
            $display("FAIL fade_out_end got lvl=%0d busy=%b rgb=%h want 0/0/0",
                     fade_level, fade_busy, {r, g, b});
        end
        tick_grey(127, 1, 1, 0);
        total++;
        if (fade_busy !== 1'b0 || fade_level !== 7'd0) begin
            bad++;
            $display("FAIL fade_out_noop got busy=%b lvl=%0d want 0/0", fade_busy, fade_level);
        end
    endtask

    task automatic test_snap();
        tick_grey(50, 2, 1, 0);
        for (int p = 0; p < 80; p++) tick_grey(50, 0, 0, 1);
        total++;
        if (fade_level !== 7'd40 || fade_busy !== 1'b1) begin
            bad++;
            $display("FAIL fade_in_40 got lvl=%0d busy=%b want 40/1", fade_level, fade_busy);
        end
        tick_grey(50, 3, 1, 0);
        total++;
        if (fade_level !== 7'd127 || fade_busy !== 1'b0) begin
            bad++;
            $display("FAIL snap got lvl=%0d busy=%b want 127/0", fade_level, fade_busy);
        end
        tick_grey(50, 1, 1, 0);
        tick_grey(50, 2, 1, 0);
        tick_grey(50, 0, 0, 1);
        tick_grey(50, 0, 0, 1);
        total++;
        if (fade_level !== 7'd126 || fade_busy !== 1'b1) begin
            bad++;
            $display("FAIL ignore_cmd_in_fade got lvl=%0d busy=%b want 126/1", fade_level, fade_busy);
        end
        tick_grey(50, 3, 1, 0);
    endtask

    task automatic test_simultaneous();
        tick_grey(10, 1, 1, 0);
        for (int p = 0; p < 254; p++) tick_grey(10, 0, 0, 1);
        total++;
        if (fade_level !== 7'd0 || fade_busy !== 1'b0) begin
            bad++;
            $display("FAIL simul_setup got lvl=%0d busy=%b want 0/0", fade_level, fade_busy);
        end
        tick_grey(10, 2, 1, 1);
        tick_grey(10, 0, 0, 1);
        total++;
        if (fade_level !== 7'd0 || fade_busy !== 1'b1) begin
            bad++;
            $display("FAIL simul_not_counted got lvl=%0d busy=%b want 0/1", fade_level, fade_busy);
        end
        tick_grey(10, 0, 0, 1);
        total++;
        if (fade_level !== 7'd1 || fade_level !== 7'(m_level)) begin
            bad++;
            $display("FAIL simul_step got lvl=%0d want 1", fade_level);
        end
    endtask

    initial begin
        reset_model();
        #11;
        test_reset();
        test_grey_latency();
        test_clamp();
        test_random();
        test_fade_out();
        test_snap();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ycocg_fade_pipe.md
Name: ycocg_fade_pipe

Overview:
- Parametrised pixel-clock output stage.
- Takes palette YCoCg samples plus timing signals and applies a frame-synchronous global luma fade.
- Converts YCoCg to RGB, then clamps and scales to the output width.
- Sits between the palette BRAM lookup and the video PHY. It replaces the fixed p2b..p7 pipeline with configurable widths and a fade engine driven by a state machine.

Parameters:
- CORDW, 11, coordinate width of sx/sy.
- YW, 7, luma width (unsigned).
- CW, 8, chroma width (Co/Cg, two's complement).
- OUTW, 8, output colour width per channel. Must be >= YW.
- FADE_STEP_FRAMES, 2, number of in_frame pulses per one-LSB fade step. Must be >= 1.

Ports:
- clk_pix  in  1  pixel clock
- rst_pix_n  in  1  asynchronous active-low reset
- in_sx  in  CORDW  horizontal position
- in_sy  in  CORDW  vertical position
- in_de  in  1  data enable
- in_hsync  in  1  horizontal sync
- in_vsync  in  1  vertical sync
- in_frame  in  1  single-cycle frame-start pulse
- in_y  in  YW  luma
- in_co  in  CW  orange chroma, signed
- in_cg  in  CW  green chroma, signed
- fade_cmd  in  2  0=nop, 1=fade out, 2=fade in, 3=snap to full
- fade_cmd_valid  in  1  command strobe
- fade_busy  out  1  high while fading
- fade_level  out  YW  current brightness level
- sx  out  CORDW  delayed horizontal position
- sy  out  CORDW  delayed vertical position
- de  out  1  delayed data enable
- hsync  out  1  delayed horizontal sync
- vsync  out  1  delayed vertical sync
- r  out  OUTW  red
- g  out  OUTW  green
- b  out  OUTW  blue

Behaviour:
- **Reset:** one clock (clk_pix); reset is asynchronous and active-low (rst_pix_n). On reset:
  - all pipeline registers and outputs are 0;
  - fade_level = YMAX (2^YW-1), FSM in IDLE, fade_busy=0, frame divider=0.
- **Latency:** fixed 5 clk_pix cycles from an input sample to the matching outputs. sx/sy/de/hsync/vsync are delayed by the same 5 stages with no transformation. No stalls.
- **S1 fade:**
  - y_f = in_y - (YMAX - fade_level), saturated at 0.
  - fade_level is sampled when the pixel enters S1.
- **Arithmetic:** all signed math uses internal width IW = max(YW+1, CW) + 2. No wrap is possible before the clamp.
  - S2: tmp = y_f - (cg >>> 1).
  - S3: g = cg + tmp; b = tmp - (co >>> 1).
  - S4: r = b + co.
- **S5 clamp and scale:**
  - Each channel is clamped to [0, YMAX].
  - It is then scaled to OUTW by left-shifting OUTW-YW and filling the low bits with the MSBs (bit replication), so YMAX maps to 2^OUTW-1.
  - r/g/b are forced to 0 when the delayed de is 0.
- **Fade FSM states:** IDLE, FADE_OUT, FADE_IN.
  - IDLE + cmd 1 with level>0 -> FADE_OUT. IDLE + cmd 2 with level<YMAX -> FADE_IN.
  - A command whose target is already reached is a no-op: stays IDLE, busy stays 0.
  - cmd 3 from any state: level=YMAX next cycle, -> IDLE, divider cleared.
  - cmd 1/2 while in FADE_OUT or FADE_IN are ignored. cmd 0 is always ignored.
  - On command acceptance the divider clears to 0.
- **Fade stepping:**
  - Each in_frame pulse increments the divider.
  - When the divider reaches FADE_STEP_FRAMES, it clears and level moves by 1 (down in FADE_OUT, up in FADE_IN).
  - When level reaches its endpoint (0 or YMAX), the FSM returns to IDLE in the same cycle as the level update, so busy drops with that update.
- **Simultaneous events:**
  - cmd_valid and in_frame in the same cycle: the command wins and that pulse is not counted.
  - in_frame in IDLE does not advance the divider.
- **Outputs:** fade_busy = (state != IDLE), registered. Level changes only on in_frame edges, so there is no mid-frame brightness tearing.
- **Reset mid-fade:** snaps to the reset state immediately (asynchronous).

Decomposition:
- vdp_pkg (shared package) holds:
  - fade_cmd_e (FADE_NOP, FADE_OUT, FADE_IN, FADE_SNAP);
  - fade_state_e;
  - a localparam function for IW.
- Sub-module ycocg_to_rgb (S2-S5 arithmetic, clamp, scale; parametrised on YW/CW/OUTW) is natural.
- The fade FSM and sync delay line stay in ycocg_fade_pipe.

Test Plan:
1. **Reset:** assert rst_pix_n low mid-stream -> all outputs 0 immediately, fade_level=127, fade_busy=0.
2. **Grey and latency:** y=64, co=0, cg=0, de=1 -> r=g=b=129 exactly 5 cycles later. sx/sy/hsync/vsync match the inputs delayed 5 cycles; de=0 gives rgb=0.
3. **Clamp:** y=127, co=+127, cg=0 -> g=255, b=129 (64), r=255 (191 clamped to 127). y=0, co=-128, cg=+127 -> all channels clamped at >= 0.
4. **Fade out** (FADE_STEP_FRAMES=2):
   - Issue cmd 1 -> busy=1; level=126 after the 2nd in_frame, so y=127 grey outputs 253.
   - After 254 pulses: level=0, busy=0, all grey outputs 0.
   - Then cmd 1 again -> no-op, busy stays 0.
5. **Snap mid-fade:** during FADE_IN at level 40, issue cmd 3 -> next cycle level=127, busy=0. cmd 1/2 issued during a fade leave the direction unchanged.
6. **Simultaneous events:** cmd 2 in the same cycle as in_frame with level=0 -> that pulse is not counted; level=1 only after 2 further pulses.
